// File: rtl/alu_op_sequencer.sv
// Drives one ALU operation from request to response: load sources, compute, wait for done, read result and overflow.
// Operations with a bad opcode or mismatched matrix dimensions are answered at once without touching the ALU.
module alu_op_sequencer #(
    parameter int STROBE_W = 2,
    parameter int READ_W   = 2,
    parameter int TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [6:0]   req_op,
    input  logic [261:0] req_a,
    input  logic [261:0] req_b,
    output logic [261:0] bus_out,
    output logic         bus_oe,
    input  logic [261:0] bus_in,
    output logic         alu_enable,
    output logic         alu_in1,
    output logic         alu_in2,
    output logic         alu_compute,
    output logic         alu_out,
    output logic         alu_over,
    output logic [6:0]   alu_operation,
    output logic         alu_reset,
    input  logic         alu_done,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [261:0] rsp_result,
    output logic [261:0] rsp_overflow,
    output logic [1:0]   rsp_status
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD1    = 3'd1;
    localparam logic [2:0] S_LOAD2    = 3'd2;
    localparam logic [2:0] S_COMPUTE  = 3'd3;
    localparam logic [2:0] S_WAIT     = 3'd4;
    localparam logic [2:0] S_READ_RES = 3'd5;
    localparam logic [2:0] S_READ_OVF = 3'd6;
    localparam logic [2:0] S_RESP     = 3'd7;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_TIMEOUT = 2'b01;
    localparam logic [1:0] ST_BAD     = 2'b10;

    localparam logic [15:0] STROBE_LAST = 16'(STROBE_W);
    localparam logic [15:0] RES_LAST    = 16'(READ_W - 1);
    localparam logic [15:0] OVF_LAST    = 16'(READ_W);
    localparam logic [15:0] WAIT_LAST   = 16'(TIMEOUT - 1);

    logic [2:0]   state;
    logic [15:0]  cnt;
    logic [6:0]   op_r;
    logic [261:0] a_r;
    logic [261:0] b_r;
    logic [2:0]   done_sync;
    logic         done_seen;
    logic         alu_reset_r;
    logic         done_edge;
    logic         accept;
    logic         skip_load2;
    logic         strobe_phase;

    function automatic logic [1:0] precheck(input logic [6:0] op, input logic [261:0] a,
                                            input logic [261:0] b);
        logic [4:0] kind;
        logic [1:0] st;
        kind = op[4:0];
        st   = ST_OK;
        if (kind == 5'd0 || (kind & (kind - 5'd1)) != 5'd0)
            st = ST_BAD;
        else if (op[5]) begin
            if ((kind[4] || kind[3] || kind[1]) && a[261:256] != b[261:256])
                st = ST_BAD;
            else if (kind[2] && a[258:256] != b[261:259])
                st = ST_BAD;
        end
        return st;
    endfunction

    assign accept     = req_valid && (state == S_IDLE);
    assign done_edge  = done_sync[1] && !done_sync[2];
    assign skip_load2 = op_r[5] && op_r[0];

    // Sources are only driven while a load state is active, so they need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= req_a;
            b_r <= req_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            op_r         <= '0;
            rsp_result   <= '0;
            rsp_overflow <= '0;
            rsp_status   <= ST_OK;
            done_sync    <= '0;
            done_seen    <= 1'b0;
            alu_reset_r  <= 1'b0;
        end else begin
            done_sync   <= {done_sync[1:0], alu_done};
            alu_reset_r <= 1'b0;
            if (done_edge)
                done_seen <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_r         <= req_op;
                        done_seen    <= 1'b0;
                        cnt          <= '0;
                        rsp_result   <= '0;
                        rsp_overflow <= '0;
                        rsp_status   <= precheck(req_op, req_a, req_b);
                        state        <= (precheck(req_op, req_a, req_b) == ST_OK) ? S_LOAD1 : S_RESP;
                    end
                end
                S_LOAD1, S_LOAD2, S_COMPUTE: begin
                    if (cnt == STROBE_LAST) begin
                        cnt <= '0;
                        if (state == S_LOAD1)
                            state <= skip_load2 ? S_COMPUTE : S_LOAD2;
                        else if (state == S_LOAD2)
                            state <= S_COMPUTE;
                        else
                            state <= S_WAIT;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_WAIT: begin
                    // A done already latched beats a timeout landing in the same cycle.
                    if (done_seen) begin
                        cnt   <= '0;
                        state <= S_READ_RES;
                    end else if (cnt == WAIT_LAST) begin
                        cnt         <= '0;
                        rsp_status  <= ST_TIMEOUT;
                        alu_reset_r <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_READ_RES: begin
                    if (cnt == RES_LAST) begin
                        rsp_result <= bus_in;
                        cnt        <= '0;
                        state      <= S_READ_OVF;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_READ_OVF: begin
                    if (cnt == OVF_LAST) begin
                        rsp_overflow <= bus_in;
                        cnt          <= '0;
                        state        <= S_RESP;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset releases the bus at once.
    assign strobe_phase  = (cnt != 16'd0);
    assign req_ready     = (state == S_IDLE);
    assign bus_oe        = (state == S_LOAD1) || (state == S_LOAD2);
    assign bus_out       = (state == S_LOAD1) ? a_r : ((state == S_LOAD2) ? b_r : '0);
    assign alu_in1       = (state == S_LOAD1) && strobe_phase;
    assign alu_in2       = (state == S_LOAD2) && strobe_phase;
    assign alu_compute   = (state == S_COMPUTE) && strobe_phase;
    assign alu_out       = (state == S_READ_RES);
    assign alu_over      = (state == S_READ_OVF) && strobe_phase;
    assign alu_enable    = alu_out || alu_over;
    assign alu_operation = op_r;
    assign alu_reset     = alu_reset_r;
    assign rsp_valid     = (state == S_RESP);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU on the bus plus directed and randomized requests
// whose expected responses are computed from the operation's arithmetic.
module tb_alu_op_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [6:0]   req_op;
    logic [261:0] req_a;
    logic [261:0] req_b;
    logic [261:0] bus_out;
    logic         bus_oe;
    logic [261:0] bus_in;
    logic         alu_enable;
    logic         alu_in1;
    logic         alu_in2;
    logic         alu_compute;
    logic         alu_out;
    logic         alu_over;
    logic [6:0]   alu_operation;
    logic         alu_reset;
    logic         alu_done;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [261:0] rsp_result;
    logic [261:0] rsp_overflow;
    logic [1:0]   rsp_status;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.STROBE_W(2), .READ_W(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
        .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .alu_compute(alu_compute), .alu_out(alu_out), .alu_over(alu_over),
        .alu_operation(alu_operation), .alu_reset(alu_reset), .alu_done(alu_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_status(rsp_status)
    );

    // Behavioural ALU: edge-strobed source latches, result after compute, async done pulse.
    logic [261:0] src1, src2, alu_res, alu_ovf;
    logic [262:0] alu_w;
    int           done_dly = 0;
    bit           done_stuck = 1'b0;

    initial alu_done = 1'b0;
    always @(posedge alu_in1) src1 = bus_out;
    always @(posedge alu_in2) src2 = bus_out;
    always @(posedge alu_compute) begin
        alu_res = '0;
        alu_ovf = '0;
        case (alu_operation)
            7'h10: begin
                alu_w   = {1'b0, src1} + {1'b0, src2};
                alu_res = alu_w[261:0];
                alu_ovf = {261'b0, alu_w[262]};
            end
            7'h08: begin
                alu_w   = {1'b0, src1} - {1'b0, src2};
                alu_res = alu_w[261:0];
                alu_ovf = {261'b0, alu_w[262]};
            end
            7'h21: begin
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++)
                        alu_res[(4*i+j)*16 +: 16] = src1[(4*j+i)*16 +: 16];
                alu_res[261:256] = {src1[258:256], src1[261:259]};
            end
            default: ;
        endcase
        if (!done_stuck) begin
            repeat (done_dly) @(posedge clk);
            #3 alu_done = 1'b1;
            repeat (3) @(posedge clk);
            #3 alu_done = 1'b0;
        end
    end

    assign bus_in = (alu_enable && alu_out) ? alu_res :
                    ((alu_enable && alu_over) ? alu_ovf : '0);

    int n_in1 = 0, n_in2 = 0, n_cmp = 0, n_viol = 0, n_arst = 0;
    always @(negedge clk) begin
        if (alu_in1) n_in1++;
        if (alu_in2) n_in2++;
        if (alu_compute) n_cmp++;
        if (alu_reset) n_arst++;
        if (bus_oe && (alu_out || alu_over)) n_viol++;
        if (int'(alu_in1) + int'(alu_in2) + int'(alu_compute) + int'(alu_out) + int'(alu_over) > 1)
            n_viol++;
    end

    task automatic check(input string tag, input logic [261:0] obs, input logic [261:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [261:0] rand262();
        logic [287:0] w;
        for (int i = 0; i < 9; i++) w[i*32 +: 32] = $urandom;
        return w[261:0];
    endfunction

    task automatic start_req(input logic [6:0] op, input logic [261:0] a, input logic [261:0] b);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic finish_rsp(input string tag, input logic [261:0] er, input logic [261:0] eo,
                              input logic [1:0] es, input int hold, output int lat);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 400);
        check_bit({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_result"}, rsp_result, er);
        check({tag, "_overflow"}, rsp_overflow, eo);
        check_int({tag, "_status"}, int'(rsp_status), int'(es));
        repeat (hold) @(negedge clk);
        if (hold > 0) begin
            check({tag, "_hold_result"}, rsp_result, er);
            check_bit({tag, "_hold_valid"}, rsp_valid, 1'b1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check_bit({tag, "_released"}, rsp_valid, 1'b0);
        check_bit({tag, "_ready_again"}, req_ready, 1'b1);
    endtask

    task automatic run_req(input string tag, input logic [6:0] op, input logic [261:0] a,
                           input logic [261:0] b, input logic [261:0] er, input logic [261:0] eo,
                           input logic [1:0] es, input int hold,
                           output int lat, output int c1, output int c2, output int c3);
        int s1, s2, s3;
        s1 = n_in1; s2 = n_in2; s3 = n_cmp;
        start_req(op, a, b);
        finish_rsp(tag, er, eo, es, hold, lat);
        c1 = n_in1 - s1; c2 = n_in2 - s2; c3 = n_cmp - s3;
    endtask

    logic [261:0] a, b, er, eo;
    logic         cy;
    int           lat, c1, c2, c3, k, sel, hold, s_arst;
    logic [6:0]   bad_ops [4] = '{7'h03, 7'h00, 7'h1F, 7'h2C};

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("rst_req_ready", req_ready, 1'b1);
        check_bit("rst_bus_oe", bus_oe, 1'b0);
        check_bit("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_bus_out", bus_out, '0);
        check_int("rst_status", int'(rsp_status), 0);
        check_int("rst_operation", int'(alu_operation), 0);
        check_int("rst_strobes", int'({alu_enable, alu_in1, alu_in2, alu_compute, alu_out, alu_over, alu_reset}), 0);
        reset = 1'b0;

        // Integer ADD with the strobe widths counted
        run_req("add5_7", 7'h10, 262'd5, 262'd7, 262'd12, '0, 2'b00, 1, lat, c1, c2, c3);
        check_int("add_in1_cycles", c1, 2);
        check_int("add_in2_cycles", c2, 2);
        check_int("add_compute_cycles", c3, 2);

        // Matrix transpose of a 4x4: source2 never loaded
        a = '0; er = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                a[(4*i+j)*16 +: 16]  = 16'(4*i + j);
                er[(4*i+j)*16 +: 16] = 16'(4*j + i);
            end
        a[261:256] = {3'd4, 3'd4}; er[261:256] = {3'd4, 3'd4};
        run_req("trans", 7'h21, a, rand262(), er, '0, 2'b00, 0, lat, c1, c2, c3);
        check_int("trans_in2_cycles", c2, 0);
        check_int("trans_in1_cycles", c1, 2);

        // Matrix MULT with incompatible dimensions
        a = rand262(); a[261:256] = {3'd2, 3'd3};
        b = rand262(); b[261:256] = {3'd2, 3'd3};
        run_req("mult_bad_dim", 7'h24, a, b, '0, '0, 2'b10, 0, lat, c1, c2, c3);
        check_int("mult_bad_latency", lat, 1);
        check_int("mult_bad_strobes", c1 + c2 + c3, 0);

        // Non-one-hot opcode, then a valid SUB right after
        run_req("op03", 7'h03, 262'd1, 262'd2, '0, '0, 2'b10, 0, lat, c1, c2, c3);
        check_int("op03_strobes", c1 + c2 + c3, 0);
        run_req("sub9_4", 7'h08, 262'd9, 262'd4, 262'd5, '0, 2'b00, 0, lat, c1, c2, c3);

        // Randomized integer ADD/SUB and rejected opcodes
        for (int t = 0; t < 12; t++) begin
            a = rand262(); b = rand262();
            sel = $urandom_range(0, 2);
            done_dly = $urandom_range(0, 5);
            hold = $urandom_range(0, 3);
            if (sel == 0) begin
                {cy, er} = {1'b0, a} + {1'b0, b};
                eo = {261'b0, cy};
                run_req("rand_add", 7'h10, a, b, er, eo, 2'b00, hold, lat, c1, c2, c3);
            end else if (sel == 1) begin
                {cy, er} = {1'b0, a} - {1'b0, b};
                eo = {261'b0, cy};
                run_req("rand_sub", 7'h08, a, b, er, eo, 2'b00, hold, lat, c1, c2, c3);
            end else begin
                run_req("rand_badop", bad_ops[$urandom_range(0, 3)], a, b, '0, '0, 2'b10, hold,
                        lat, c1, c2, c3);
            end
            check_int("rand_in1_cycles", c1, (sel == 2) ? 0 : 2);
        end
        done_dly = 0;

        // Hung ALU: timeout counted from WAIT_DONE entry
        done_stuck = 1'b1;
        s_arst = n_arst;
        start_req(7'h10, 262'd1, 262'd1);
        k = 0;
        while (!alu_compute && k < 50) begin @(negedge clk); k++; end
        check_bit("to_compute_seen", alu_compute, 1'b1);
        k = 0;
        while (alu_compute && k < 50) begin @(negedge clk); k++; end
        k = 0;
        while (!rsp_valid && k < 400) begin @(negedge clk); k++; end
        check_int("to_cycles", k, 64);
        check_int("to_status", int'(rsp_status), 1);
        check_bit("to_alu_reset_on", alu_reset, 1'b1);
        check("to_result", rsp_result, '0);
        @(negedge clk);
        check_bit("to_alu_reset_off", alu_reset, 1'b0);
        finish_rsp("to_rsp", '0, '0, 2'b01, 0, lat);
        check_int("to_alu_reset_cycles", n_arst - s_arst, 1);
        done_stuck = 1'b0;

        // Reset asserted during LOAD2
        start_req(7'h10, 262'd3, 262'd4);
        k = 0;
        while (!alu_in2 && k < 50) begin @(negedge clk); k++; end
        check_bit("load2_reached", alu_in2, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_bit("rl2_bus_oe", bus_oe, 1'b0);
        check_bit("rl2_in2", alu_in2, 1'b0);
        check_bit("rl2_req_ready", req_ready, 1'b1);
        @(negedge clk) reset = 1'b0;
        run_req("after_rl2", 7'h10, 262'd20, 262'd22, 262'd42, '0, 2'b00, 0, lat, c1, c2, c3);

        // Reset asserted during READ_RES
        start_req(7'h08, 262'd50, 262'd8);
        k = 0;
        while (!alu_out && k < 100) begin @(negedge clk); k++; end
        check_bit("readres_reached", alu_out, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_bit("rrr_alu_out", alu_out, 1'b0);
        check_bit("rrr_enable", alu_enable, 1'b0);
        check_bit("rrr_req_ready", req_ready, 1'b1);
        check_bit("rrr_rsp_valid", rsp_valid, 1'b0);
        @(negedge clk) reset = 1'b0;
        repeat (6) @(negedge clk);
        run_req("after_rrr", 7'h08, 262'd100, 262'd1, 262'd99, '0, 2'b00, 2, lat, c1, c2, c3);

        check_int("bus_strobe_violations", n_viol, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
